// File: rtl/mul_pkg.sv
// mul_pkg -- definitions shared by the multiplier front-end slice.
//   XLEN_DEFAULT : default operand/result width
//   mul_op_e     : RISC-V M-extension multiply op codes
//   src1_signed / src2_signed / sel_high : op decode helpers
package mul_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    // src1 is treated as signed for every op except MULHU
    function automatic logic src1_signed(input mul_op_e op);
        return (op != OP_MULHU);
    endfunction

    // src2 is treated as signed only for MUL and MULH
    function automatic logic src2_signed(input mul_op_e op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

    // every op except MUL returns the upper half of the product
    function automatic logic sel_high(input mul_op_e op);
        return (op != OP_MUL);
    endfunction

endpackage

// File: rtl/mul_frontend_chk.sv
// mul_frontend_chk -- simulation-only protocol checker for mul_frontend.
//   Flags result FIFO overflow, metadata FIFO overflow/underflow and any
//   disagreement between the in-flight counter and the metadata occupancy.
module mul_frontend_chk #(
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             reset,
    input logic             res_push,
    input logic             res_pop,
    input logic             res_full,
    input logic             meta_push,
    input logic             meta_pop,
    input logic             meta_full,
    input logic             meta_empty,
    input logic [CNT_W-1:0] meta_count,
    input logic [CNT_W-1:0] inflight
);

    // per-cycle invariant checks, suppressed while reset is applied
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(res_push && res_full && !res_pop))
                else $error("mul_frontend: result FIFO overflow");
            assert (!(meta_push && meta_full && !meta_pop))
                else $error("mul_frontend: metadata FIFO overflow");
            assert (!(meta_pop && meta_empty))
                else $error("mul_frontend: metadata FIFO underflow");
            assert (meta_count == inflight)
                else $error("mul_frontend: inflight and metadata count disagree");
        end
    end

endmodule

// File: rtl/mul_sync_fifo.sv
// mul_sync_fifo -- generic single-clock FIFO with registered storage.
//   clk, reset      : clock, synchronous active-high reset (clears pointers/count)
//   push, push_data : write strobe and data (a push while full is accepted only
//                     together with a pop)
//   pop, pop_data   : read strobe; pop_data shows the head entry (from registers)
//   count, empty, full : occupancy status
module mul_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == CNT_W'(DEPTH));
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // pointer and occupancy tracking; DEPTH is a power of two so pointers wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mul_frontend.sv
// mul_frontend -- issue/return front end for a fixed 2-cycle multiplier.
//   Extends operands to XLEN+1 bits by op, issues them under a credit scheme
//   that guarantees room in the result FIFO (the multiplier cannot be stalled),
//   tracks {op, tag} per in-flight product and returns results in order.
//   Ports: clk, reset (sync, active-high); req_* request handshake;
//          mul_in_* / mul_src* issue side; mul_out_valid / mul_result return;
//          resp_* response handshake.
//   Build option: MUL_FRONTEND_BYPASS_EN -- when defined, a returning product
//   goes straight to resp_* if the result FIFO is empty and resp_ready is high.
module mul_frontend
    import mul_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int TAG_W     = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [XLEN-1:0]   req_src1,
    input  logic [XLEN-1:0]   req_src2,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              mul_in_valid,
    input  logic              mul_in_ready,
    output logic [XLEN:0]     mul_src1,
    output logic [XLEN:0]     mul_src2,
    input  logic              mul_out_valid,
    input  logic [2*XLEN-1:0] mul_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic [TAG_W-1:0]  resp_tag
);

    localparam int CNT_W  = $clog2(RES_DEPTH) + 1;
    localparam int META_W = 2 + TAG_W;
    localparam int RES_W  = XLEN + TAG_W;

    mul_op_e           req_op_s;
    mul_op_e           meta_op_s;
    logic              credit_ok_s;
    logic              issue_s;
    logic              ret_s;
    logic              bypass_s;
    logic              res_push_s;
    logic              res_pop_s;
    logic [CNT_W-1:0]  inflight_r;
    logic [CNT_W-1:0]  res_count_s;
    logic [CNT_W-1:0]  meta_count_s;
    logic              res_empty_s;
    logic              res_full_s;
    logic              meta_empty_s;
    logic              meta_full_s;
    logic [META_W-1:0] meta_head_s;
    logic [RES_W-1:0]  res_head_s;
    logic [XLEN-1:0]   sel_data_s;

    assign req_op_s = mul_op_e'(req_op);

    // operand extension: the extra top bit carries the sign only for signed sources
    always_comb begin
        mul_src1 = {req_src1[XLEN-1] & src1_signed(req_op_s), req_src1};
        mul_src2 = {req_src2[XLEN-1] & src2_signed(req_op_s), req_src2};
    end

    // a slot is reserved for every in-flight product, so credit covers both
    assign credit_ok_s  = ~reset &
        (({1'b0, inflight_r} + {1'b0, res_count_s}) < (CNT_W + 1)'(RES_DEPTH));
    assign mul_in_valid = req_valid & credit_ok_s;
    assign req_ready    = mul_in_ready & credit_ok_s;
    assign issue_s      = mul_in_valid & mul_in_ready;
    // strobes with nothing outstanding (e.g. after a reset) are dropped
    assign ret_s        = ~reset & mul_out_valid & (inflight_r != {CNT_W{1'b0}});

    // in-flight product counter
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_r <= {CNT_W{1'b0}};
        end else begin
            case ({issue_s, ret_s})
                2'b10:   inflight_r <= inflight_r + CNT_W'(1);
                2'b01:   inflight_r <= inflight_r - CNT_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    mul_sync_fifo #(
        .WIDTH (META_W),
        .DEPTH (RES_DEPTH)
    ) u_meta_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (issue_s),
        .push_data ({req_op, req_tag}),
        .pop       (ret_s),
        .pop_data  (meta_head_s),
        .count     (meta_count_s),
        .empty     (meta_empty_s),
        .full      (meta_full_s)
    );

    assign meta_op_s = mul_op_e'(meta_head_s[META_W-1 -: 2]);

    // result half selection for the oldest outstanding op
    always_comb begin
        if (sel_high(meta_op_s)) begin
            sel_data_s = mul_result[2*XLEN-1:XLEN];
        end else begin
            sel_data_s = mul_result[XLEN-1:0];
        end
    end

    // bypass decision; without the build option every result goes through the FIFO
    always_comb begin
        res_push_s = ret_s;
        bypass_s   = 1'b0;
`ifdef MUL_FRONTEND_BYPASS_EN
        bypass_s   = ret_s & res_empty_s & resp_ready;
        res_push_s = ret_s & ~bypass_s;
`endif
    end

    mul_sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (res_push_s),
        .push_data ({sel_data_s, meta_head_s[TAG_W-1:0]}),
        .pop       (res_pop_s),
        .pop_data  (res_head_s),
        .count     (res_count_s),
        .empty     (res_empty_s),
        .full      (res_full_s)
    );

    assign resp_valid = ~reset & (bypass_s | ~res_empty_s);
    assign res_pop_s  = resp_valid & resp_ready & ~bypass_s;
    assign resp_data  = bypass_s ? sel_data_s : res_head_s[RES_W-1:TAG_W];
    assign resp_tag   = bypass_s ? meta_head_s[TAG_W-1:0] : res_head_s[TAG_W-1:0];

`ifndef SYNTHESIS
    mul_frontend_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .res_push   (res_push_s),
        .res_pop    (res_pop_s),
        .res_full   (res_full_s),
        .meta_push  (issue_s),
        .meta_pop   (ret_s),
        .meta_full  (meta_full_s),
        .meta_empty (meta_empty_s),
        .meta_count (meta_count_s),
        .inflight   (inflight_r)
    );
`endif

endmodule

// File: tb/tb_mul_frontend.sv
// tb_mul_frontend -- self-checking bench for mul_frontend (default parameters).
// Includes a behavioural 2-cycle multiplier, a scoreboard fed from an
// arithmetic reference of the four multiply ops, directed vectors and
// randomized traffic.
module tb_mul_frontend;

`ifdef MUL_FRONTEND_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic [3:0]  req_tag;
    logic        mul_in_valid;
    logic        mul_in_ready;
    logic [32:0] mul_src1;
    logic [32:0] mul_src2;
    logic        mul_out_valid;
    logic [63:0] mul_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [3:0]  resp_tag;

    int tests = 0;
    int fails = 0;
    int issue_count = 0;

    logic [35:0] exp_q[$];
    logic [3:0]  got_tags[$];

    logic        p1_v, p2_v, stray;
    logic [63:0] p1_d, p2_d;

    mul_frontend dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_src1      (req_src1),
        .req_src2      (req_src2),
        .req_tag       (req_tag),
        .mul_in_valid  (mul_in_valid),
        .mul_in_ready  (mul_in_ready),
        .mul_src1      (mul_src1),
        .mul_src2      (mul_src2),
        .mul_out_valid (mul_out_valid),
        .mul_result    (mul_result),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: multiply op result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            2'b00:   begin p = ua * ub; return p[31:0];  end
            2'b01:   begin p = sa * sb; return p[63:32]; end
            2'b10:   begin p = sa * ub; return p[63:32]; end
            default: begin p = ua * ub; return p[63:32]; end
        endcase
    endfunction

    // External multiplier: signed (XLEN+1)x(XLEN+1) product
    function automatic logic [63:0] prod33(input logic [32:0] a, input logic [32:0] b);
        logic signed [32:0] sa, sb;
        logic signed [65:0] p;
        sa = a;
        sb = b;
        p  = sa * sb;
        return p[63:0];
    endfunction

    // 2-cycle multiplier pipeline (not reset, so stale strobes survive a DUT reset)
    always @(posedge clk) begin
        p1_v <= mul_in_valid & mul_in_ready;
        p1_d <= prod33(mul_src1, mul_src2);
        p2_v <= p1_v;
        p2_d <= p1_d;
    end
    assign mul_out_valid = p2_v | stray;
    assign mul_result    = p2_d;

    // Monitor/scoreboard on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            if (req_valid && req_ready) begin
                exp_q.push_back({ref_result(req_op, req_src1, req_src2), req_tag});
                chk("mul_in_valid", 64'(mul_in_valid), 64'd1);
                chk("mul_src1", 64'(mul_src1), 64'({req_src1[31] & (req_op != 2'b11), req_src1}));
                chk("mul_src2", 64'(mul_src2), 64'({req_src2[31] & (req_op[1] == 1'b0), req_src2}));
                issue_count++;
            end
            if (resp_valid && resp_ready) begin
                got_tags.push_back(resp_tag);
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    logic [35:0] e;
                    e = exp_q.pop_front();
                    chk("resp_data", 64'(resp_data), 64'(e[35:4]));
                    chk("resp_tag", 64'(resp_tag), 64'(e[3:0]));
                end
            end
        end
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        logic got;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = v.op; req_src1 = v.a; req_src2 = v.b; req_tag = 4'(idx);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        chk({"issue_", v.name}, 64'(got), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                lat = i;
            end
        end
        chk({"latency_", v.name}, 64'(lat), 64'(LAT));
        chk({"data_", v.name}, 64'(resp_data), 64'(v.exp));
        repeat (2) @(posedge clk);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1; req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd0; req_src2 = 32'd0;
        req_tag = 4'd0; mul_in_ready = 1'b1; resp_ready = 1'b1; stray = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_mul_in_valid", 64'(mul_in_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;

        // directed vectors
        vecs[0] = '{"mul_7xm3",        2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1] = '{"mulh_min_min",    2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2] = '{"mulhu_max_max",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3] = '{"mulhsu_m1_max",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{"mulhsu_2_min",    2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001};
        vecs[5] = '{"mul_3x5",         2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F};
        vecs[6] = '{"mulh_m1_m1",      2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7] = '{"mulhu_min_2",     2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // randomized traffic with random backpressure on both sides
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            req_valid    = ($urandom_range(0, 9) < 6);
            req_op       = 2'($urandom_range(0, 3));
            req_src1     = rnd_operand();
            req_src2     = rnd_operand();
            req_tag      = 4'($urandom_range(0, 15));
            resp_ready   = ($urandom_range(0, 9) < 7);
            mul_in_ready = ($urandom_range(0, 9) < 8);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; resp_ready = 1'b1; mul_in_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_random", 64'(exp_q.size()), 64'd0);

        // credit limit: six requests with responses blocked
        got_tags.delete();
        base = issue_count;
        resp_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            req_valid = ((issue_count - base) < 6);
            req_tag   = 4'(issue_count - base);
            req_op    = 2'b00;
            req_src1  = $urandom;
            req_src2  = $urandom;
        end
        @(negedge clk);
        chk("credit_issued", 64'(issue_count - base), 64'd4);
        chk("credit_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        for (int c = 0; c < 40 && got_tags.size() < 6; c++) begin
            @(posedge clk); #1;
            req_valid = ((issue_count - base) < 6);
            req_tag   = 4'(issue_count - base);
        end
        req_valid = 1'b0;
        chk("credit_resp_count", 64'(got_tags.size()), 64'd6);
        for (int i = 0; i < 6 && i < got_tags.size(); i++) begin
            chk("credit_tag_order", 64'(got_tags[i]), 64'(i));
        end

        // reset one cycle after an issue, then stray strobes
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd3; req_src2 = 32'd5; req_tag = 4'd9;
        @(negedge clk);
        chk("rst_mid_issue", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_mid_inflight", 64'(dut.inflight_r), 64'd0);
        end
        chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
